// File: rtl/avr_pp_sequencer.sv
// avr_pp_sequencer
// Turns single host commands into timed AVR high-voltage parallel programming
// pin activity: mode lines and data byte, then an XTAL/PAGEL/WR/OE strobe,
// then (for WRITE) a wait on RDY/BSY. All pin outputs are flops.
// Optional feature macro: AVR_PP_SEQUENCER_TIMEOUT_EN bounds the RDY wait and
// reports a timeout on err; without it WAIT_RDY only exits on rdy or rst_n.
module avr_pp_sequencer #(
  parameter int SETUP_CYCLES   = 2,
  parameter int PULSE_CYCLES   = 4,
  parameter int BSY_WINDOW     = 16,
  parameter int TIMEOUT_CYCLES = 48000
) (
  input  logic       osc,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd,
  input  logic [7:0] arg,
  input  logic       dut_rdy,
  input  logic [7:0] dut_data_in,
  output logic       dut_xtal,
  output logic       dut_pagel,
  output logic       dut_wr,
  output logic       dut_oe,
  output logic       dut_xa0,
  output logic       dut_xa1,
  output logic       dut_bs1,
  output logic       dut_bs2,
  output logic [7:0] dut_data,
  output logic       dut_data_oe,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       err
);

  localparam logic [2:0] OP_LOAD_CMD = 3'd0;
  localparam logic [2:0] OP_ADDR_LO  = 3'd1;
  localparam logic [2:0] OP_ADDR_HI  = 3'd2;
  localparam logic [2:0] OP_DATA_LO  = 3'd3;
  localparam logic [2:0] OP_DATA_HI  = 3'd4;
  localparam logic [2:0] OP_PAGEL    = 3'd5;
  localparam logic [2:0] OP_WRITE    = 3'd6;
  localparam logic [2:0] OP_READ     = 3'd7;

  // One shared phase counter, wide enough for the longest wait.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > BSY_WINDOW) ? TIMEOUT_CYCLES : BSY_WINDOW;
  localparam int CNT_W   = (CNT_MAX > 255) ? $clog2(CNT_MAX + 1) : 8;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t SETUP_LAST = cnt_t'(SETUP_CYCLES - 1);
  localparam cnt_t PULSE_LAST = cnt_t'(PULSE_CYCLES - 1);
  localparam cnt_t BSY_LAST   = cnt_t'(BSY_WINDOW - 1);
`ifdef AVR_PP_SEQUENCER_TIMEOUT_EN
  localparam cnt_t TIMEOUT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    PULSE    = 3'd2,
    HOLD     = 3'd3,
    BSY_LO   = 3'd4,
    WAIT_RDY = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  cnt_t       cnt_r;
  logic [2:0] cmd_r;
  logic       rdy_meta_r;
  logic       rdy_sync_r;
  logic       accept_s;
  logic       pulse_next_s;
`ifdef AVR_PP_SEQUENCER_TIMEOUT_EN
  logic       timeout_s;
  logic       err_r;
`endif

  logic       cmd_ready_r;
  logic       xtal_r;
  logic       pagel_r;
  logic       wr_r;
  logic       oe_r;
  logic       xa0_r;
  logic       xa1_r;
  logic       bs1_r;
  logic       bs2_r;
  logic [7:0] data_r;
  logic       data_oe_r;
  logic [7:0] rd_data_r;
  logic       done_r;

  assign accept_s     = cmd_valid && (state_r == IDLE);
  assign pulse_next_s = (state_next_s == PULSE);

  // Next-state decode: each timed phase ends when the counter hits its last cycle.
  always_comb begin
    state_next_s = state_r;
`ifdef AVR_PP_SEQUENCER_TIMEOUT_EN
    timeout_s = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = SETUP;
        else          state_next_s = IDLE;
      end
      SETUP: begin
        if (cnt_r == SETUP_LAST) state_next_s = PULSE;
        else                     state_next_s = SETUP;
      end
      PULSE: begin
        if (cnt_r == PULSE_LAST) state_next_s = HOLD;
        else                     state_next_s = PULSE;
      end
      HOLD: begin
        if (cnt_r == SETUP_LAST) state_next_s = (cmd_r == OP_WRITE) ? BSY_LO : DONE;
        else                     state_next_s = HOLD;
      end
      BSY_LO: begin
        // A fast device may finish before we ever see BSY; the window bounds that.
        if (!rdy_sync_r)             state_next_s = WAIT_RDY;
        else if (cnt_r == BSY_LAST)  state_next_s = DONE;
        else                         state_next_s = BSY_LO;
      end
      WAIT_RDY: begin
        if (rdy_sync_r) begin
          state_next_s = DONE;
        end else begin
`ifdef AVR_PP_SEQUENCER_TIMEOUT_EN
          if (cnt_r == TIMEOUT_LAST) begin
            state_next_s = DONE;
            timeout_s    = 1'b1;
          end else begin
            state_next_s = WAIT_RDY;
          end
`else
          state_next_s = WAIT_RDY;
`endif
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register and phase counter (restarts on every state change).
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (state_next_s != state_r) cnt_r <= {CNT_W{1'b0}};
      else                         cnt_r <= cnt_r + cnt_t'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous RDY/BSY pin (idles high).
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      rdy_meta_r <= 1'b1;
      rdy_sync_r <= 1'b1;
    end else begin
      rdy_meta_r <= dut_rdy;
      rdy_sync_r <= rdy_meta_r;
    end
  end

  // Latch mode lines and data byte at acceptance; unspecified lines keep their value.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r     <= 3'd0;
      xa0_r     <= 1'b0;
      xa1_r     <= 1'b0;
      bs1_r     <= 1'b0;
      bs2_r     <= 1'b0;
      data_r    <= 8'h00;
      data_oe_r <= 1'b1;
    end else if (accept_s) begin
      cmd_r     <= cmd;
      data_oe_r <= (cmd != OP_READ);
      case (cmd)
        OP_LOAD_CMD: begin xa1_r <= 1'b1; xa0_r <= 1'b0; bs1_r <= 1'b0; data_r <= arg; end
        OP_ADDR_LO:  begin xa1_r <= 1'b0; xa0_r <= 1'b0; bs1_r <= 1'b0; data_r <= arg; end
        OP_ADDR_HI:  begin xa1_r <= 1'b0; xa0_r <= 1'b0; bs1_r <= 1'b1; data_r <= arg; end
        OP_DATA_LO:  begin xa1_r <= 1'b0; xa0_r <= 1'b1; bs1_r <= 1'b0; data_r <= arg; end
        OP_DATA_HI:  begin xa1_r <= 1'b0; xa0_r <= 1'b1; bs1_r <= 1'b1; data_r <= arg; end
        OP_PAGEL:    begin bs1_r <= 1'b1; end
        OP_WRITE:    begin bs1_r <= arg[0]; bs2_r <= arg[1]; end
        OP_READ:     begin bs1_r <= arg[0]; bs2_r <= arg[1]; end
        default:     begin bs1_r <= bs1_r; end
      endcase
    end else if (state_r == DONE) begin
      data_oe_r <= 1'b1;
    end else begin
      data_oe_r <= data_oe_r;
    end
  end

  // Strobes, done and ready are decoded from the next state so they line up with it.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      xtal_r      <= 1'b0;
      pagel_r     <= 1'b0;
      wr_r        <= 1'b1;
      oe_r        <= 1'b1;
      done_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      xtal_r      <= pulse_next_s && (cmd_r < OP_PAGEL);
      pagel_r     <= pulse_next_s && (cmd_r == OP_PAGEL);
      wr_r        <= !(pulse_next_s && (cmd_r == OP_WRITE));
      oe_r        <= !(pulse_next_s && (cmd_r == OP_READ));
      done_r      <= (state_next_s == DONE);
      cmd_ready_r <= (state_next_s == IDLE);
    end
  end

  // Capture the read-back byte on the last OE-active cycle.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= 8'h00;
    end else if ((state_r == PULSE) && (cnt_r == PULSE_LAST) && (cmd_r == OP_READ)) begin
      rd_data_r <= dut_data_in;
    end else begin
      rd_data_r <= rd_data_r;
    end
  end

`ifdef AVR_PP_SEQUENCER_TIMEOUT_EN
  // Timeout status accompanies the done pulse only.
  always_ff @(posedge osc or negedge rst_n) begin
    if (!rst_n) err_r <= 1'b0;
    else        err_r <= (state_next_s == DONE) && timeout_s;
  end
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign cmd_ready   = cmd_ready_r;
  assign dut_xtal    = xtal_r;
  assign dut_pagel   = pagel_r;
  assign dut_wr      = wr_r;
  assign dut_oe      = oe_r;
  assign dut_xa0     = xa0_r;
  assign dut_xa1     = xa1_r;
  assign dut_bs1     = bs1_r;
  assign dut_bs2     = bs2_r;
  assign dut_data    = data_r;
  assign dut_data_oe = data_oe_r;
  assign rd_data     = rd_data_r;
  assign done        = done_r;

endmodule

// File: tb/tb_avr_pp_sequencer.sv
// Bench for avr_pp_sequencer: a cycle-schedule model checked every cycle,
// plus directed commands with hand-computed literal expectations.
module tb_avr_pp_sequencer;

  localparam int S = 2;
  localparam int P = 4;
  localparam int W = 16;
  localparam int T = 48000;

  logic       osc = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd = 3'd0;
  logic [7:0] arg = 8'h00;
  logic       dut_rdy = 1'b1;
  logic [7:0] dut_data_in = 8'h00;
  logic       cmd_ready, dut_xtal, dut_pagel, dut_wr, dut_oe;
  logic       dut_xa0, dut_xa1, dut_bs1, dut_bs2, dut_data_oe, done, err;
  logic [7:0] dut_data, rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  avr_pp_sequencer #(
    .SETUP_CYCLES(S), .PULSE_CYCLES(P), .BSY_WINDOW(W), .TIMEOUT_CYCLES(T)
  ) dut (
    .osc(osc), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd(cmd), .arg(arg), .dut_rdy(dut_rdy), .dut_data_in(dut_data_in),
    .dut_xtal(dut_xtal), .dut_pagel(dut_pagel), .dut_wr(dut_wr), .dut_oe(dut_oe),
    .dut_xa0(dut_xa0), .dut_xa1(dut_xa1), .dut_bs1(dut_bs1), .dut_bs2(dut_bs2),
    .dut_data(dut_data), .dut_data_oe(dut_data_oe), .rd_data(rd_data),
    .done(done), .err(err)
  );

  always #5 osc = ~osc;
  always @(posedge osc) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge osc);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  // A command accepted in cycle acc is busy in acc+1..m_done. Strobe window and
  // done cycle follow from S/P; for WRITE the done cycle is found from the raw
  // rdy history delayed by two cycles.
  bit         m_busy = 1'b0;
  int         m_acc = 0;
  int         m_done = -1;
  logic [2:0] m_op = 3'd0;
  bit         m_low = 1'b0;
  int         m_low_c = 0;
  bit         m_err = 1'b0;
  logic       m_r1 = 1'b1, m_r2 = 1'b1;
  logic [7:0] m_data = 8'h00, m_rd = 8'h00;
  logic       m_xa0 = 1'b0, m_xa1 = 1'b0, m_bs1 = 1'b0, m_bs2 = 1'b0;

  initial begin
    int  c, h;
    bit  in_cmd, on, exp_done, sync;
    forever begin
      @(negedge osc);
      c = cyc;
      if (!rst_n) begin
        m_busy = 1'b0; m_done = -1; m_data = 8'h00; m_rd = 8'h00;
        m_xa0 = 1'b0; m_xa1 = 1'b0; m_bs1 = 1'b0; m_bs2 = 1'b0;
        m_r1 = 1'b1; m_r2 = 1'b1; m_err = 1'b0;
      end
      in_cmd   = m_busy && (c > m_acc) && ((m_done < 0) || (c <= m_done));
      on       = in_cmd && (c >= m_acc + 1 + S) && (c <= m_acc + S + P);
      exp_done = in_cmd && (m_done >= 0) && (c == m_done);
      chk("cmd_ready", cmd_ready, !in_cmd);
      chk("xtal", dut_xtal, on && (m_op <= 3'd4));
      chk("pagel", dut_pagel, on && (m_op == 3'd5));
      chk("wr_n", dut_wr, !(on && (m_op == 3'd6)));
      chk("oe_n", dut_oe, !(on && (m_op == 3'd7)));
      chk("lines", {dut_xa1, dut_xa0, dut_bs1, dut_bs2}, {m_xa1, m_xa0, m_bs1, m_bs2});
      chk("data", dut_data, m_data);
      chk("data_oe", dut_data_oe, !(in_cmd && (m_op == 3'd7)));
      chk("rd_data", rd_data, m_rd);
      chk("done", done, exp_done);
      chk("err", err, exp_done && m_err);
      if (rst_n) begin
        sync = m_r2;
        if (in_cmd) begin
          if ((m_op == 3'd7) && (c == m_acc + S + P)) m_rd = dut_data_in;
          h = m_acc + 2 * S + P;
          if ((m_op == 3'd6) && (m_done < 0) && (c > h)) begin
            if (!m_low) begin
              if (!sync) begin m_low = 1'b1; m_low_c = c; end
              else if (c == h + W) m_done = c + 1;
            end else begin
              if (sync) m_done = c + 1;
`ifdef AVR_PP_SEQUENCER_TIMEOUT_EN
              else if (c == m_low_c + T) begin m_done = c + 1; m_err = 1'b1; end
`endif
            end
          end
          if (c == m_done) m_busy = 1'b0;
        end
        m_r2 = m_r1;
        m_r1 = dut_rdy;
        if (!in_cmd && cmd_valid) begin
          m_busy = 1'b1; m_acc = c; m_op = cmd; m_low = 1'b0; m_err = 1'b0;
          m_done = (cmd == 3'd6) ? -1 : c + 2 * S + P + 1;
          case (cmd)
            3'd0: begin m_xa1 = 1'b1; m_xa0 = 1'b0; m_bs1 = 1'b0; m_data = arg; end
            3'd1: begin m_xa1 = 1'b0; m_xa0 = 1'b0; m_bs1 = 1'b0; m_data = arg; end
            3'd2: begin m_xa1 = 1'b0; m_xa0 = 1'b0; m_bs1 = 1'b1; m_data = arg; end
            3'd3: begin m_xa1 = 1'b0; m_xa0 = 1'b1; m_bs1 = 1'b0; m_data = arg; end
            3'd4: begin m_xa1 = 1'b0; m_xa0 = 1'b1; m_bs1 = 1'b1; m_data = arg; end
            3'd5: m_bs1 = 1'b1;
            default: begin m_bs1 = arg[0]; m_bs2 = arg[1]; end
          endcase
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [2:0] op, input logic [7:0] a, output int n);
    int k;
    k = 0;
    while (!cmd_ready && k < 1000) begin tick(); k++; end
    if (!cmd_ready) chk("ready_wait", 32'd0, 32'd1);
    cmd = op; arg = a; cmd_valid = 1'b1;
    n = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int dc);
    int k;
    dc = -1;
    for (k = 0; k < limit; k++) begin
      if (done) begin dc = cyc; break; end
      tick();
    end
    if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n, dc, r, oe_low, doe_low, cnt;
    logic [7:0] args [6];
    args = '{8'h3C, 8'h81, 8'h42, 8'h99, 8'hE7, 8'h00};

    // Reset state
    repeat (3) tick();
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_strobes", {dut_xtal, dut_pagel, dut_wr, dut_oe}, 4'b0011);
    chk("rst_data_oe", dut_data_oe, 1'b1);
    chk("rst_data", dut_data, 8'h00);
    rst_n = 1'b1;
    repeat (2) tick();

    // ADDR_LO 0x5A timing
    issue(3'd1, 8'h5A, n);
    chk("a_lo_data", dut_data, 8'h5A);
    chk("a_lo_lines", {dut_xa1, dut_xa0, dut_bs1}, 3'b000);
    tick(); chk("xtal_n2", dut_xtal, 1'b0);
    tick(); chk("xtal_n3", dut_xtal, 1'b1);
    repeat (3) tick();
    chk("xtal_n6", dut_xtal, 1'b1);
    tick(); chk("xtal_n7", dut_xtal, 1'b0);
    tick(); chk("done_n8", done, 1'b0);
    tick(); chk("done_n9", done, 1'b1); chk("cyc_n9", cyc, n + 9);
    tick(); chk("ready_n10", cmd_ready, 1'b1); chk("done_n10", done, 1'b0);

    // LOAD_CMD 0x10 then READ
    issue(3'd0, 8'h10, n);
    chk("load_lines", {dut_xa1, dut_xa0, dut_bs1}, 3'b100);
    wait_done(50, dc);
    tick();
    dut_data_in = 8'hC3;
    issue(3'd7, 8'h01, n);
    chk("rd_data_oe", dut_data_oe, 1'b0);
    chk("rd_bs", {dut_bs1, dut_bs2}, 2'b10);
    chk("rd_keep_data", dut_data, 8'h10);
    oe_low = 0; doe_low = 0;
    for (int k = 0; k < 50; k++) begin
      if (!dut_oe) oe_low++;
      if (!dut_data_oe) doe_low++;
      if (done) break;
      tick();
    end
    chk("rd_done_cyc", cyc, n + 9);
    chk("rd_value", rd_data, 8'hC3);
    chk("oe_width", oe_low, 4);
    chk("data_oe_low", doe_low, 9);
    tick();
    chk("rd_data_oe_back", dut_data_oe, 1'b1);
    dut_data_in = 8'h5E;

    // Opcodes 0..5 back to back
    for (int i = 0; i < 6; i++) begin
      issue(i[2:0], args[i], n);
      wait_done(50, dc);
      chk("op_done_cyc", dc, n + 9);
      tick();
    end
    chk("after_pagel_data", dut_data, 8'hE7);
    chk("after_pagel_lines", {dut_xa1, dut_xa0, dut_bs1}, 3'b011);
    chk("rd_unchanged", rd_data, 8'hC3);

    // WRITE: BSY seen, rdy returns after 100 cycles
    dut_rdy = 1'b1;
    issue(3'd6, 8'h02, n);
    chk("wr_bs", {dut_bs1, dut_bs2}, 2'b01);
    while (cyc < n + 6) tick();
    dut_rdy = 1'b0;
    repeat (100) tick();
    dut_rdy = 1'b1;
    r = cyc;
    wait_done(20, dc);
    chk("wr_done_after_rise", dc, r + 3);
    chk("wr_err", err, 1'b0);
    tick();

    // WRITE: rdy never falls, window expiry
    issue(3'd6, 8'h00, n);
    wait_done(100, dc);
    chk("wr_window_done", dc, n + 2 * S + P + W + 1);
    chk("wr_window_err", err, 1'b0);
    tick();

    // WRITE: rdy stuck low
    dut_rdy = 1'b0;
    issue(3'd6, 8'h01, n);
`ifdef AVR_PP_SEQUENCER_TIMEOUT_EN
    wait_done(T + 200, dc);
    chk("timeout_done", dc, n + 2 * S + P + T + 2);
    chk("timeout_err", err, 1'b1);
    tick();
`else
    cnt = 0;
    repeat (2000) begin
      if (done) cnt++;
      tick();
    end
    chk("stuck_no_done", cnt, 0);
    chk("stuck_busy", cmd_ready, 1'b0);
`endif
    rst_n = 1'b0;
    tick();
    dut_rdy = 1'b1;
    rst_n = 1'b1;
    repeat (2) tick();

    // cmd_valid held while busy, reset during PULSE
    cmd = 3'd0; arg = 8'h77; cmd_valid = 1'b1;
    n = cyc;
    tick();
    cmd = 3'd7; arg = 8'h03;
    tick();
    chk("busy_ignored_oe", dut_data_oe, 1'b1);
    chk("busy_ready", cmd_ready, 1'b0);
    while (cyc < n + 4) tick();
    chk("pulse_before_rst", dut_xtal, 1'b1);
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    #1;
    chk("rst_mid_xtal", dut_xtal, 1'b0);
    chk("rst_mid_data", dut_data, 8'h00);
    chk("rst_mid_lines", {dut_xa1, dut_xa0, dut_bs1, dut_bs2}, 4'b0000);
    chk("rst_mid_ready", cmd_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      if (done) cnt++;
      tick();
    end
    chk("rst_no_done", cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cycle %0d: got running expected finished", cyc);
    $fatal(1, "watchdog");
  end

endmodule
